// File: rtl/rbm_hidden_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbm_hidden_seq_pkg
// Description : Shared definitions for the sequential RBM hidden layer:
//               sequencer state encoding, accumulator/address width helpers,
//               LFSR feedback taps and the zero-seed substitute.
// Revision    : 1.0 - initial release
// ============================================================================
package rbm_hidden_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_ACT   = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // x^16 + x^14 + x^13 + x^11 : feedback from bits 15, 13, 12, 10
  localparam logic [15:0] c_lfsr_taps     = 16'hB400;
  // An all-zero LFSR would lock up, so a zero seed is replaced by this value
  localparam logic [15:0] c_seed_zero_sub = 16'h0001;

  // Sum of IN_DIM full-width products plus a bias cannot overflow this width
  function automatic int acc_width(input int in_bits, input int in_dim);
    return 2 * in_bits + $clog2(in_dim) + 1;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Fibonacci step, shifting left, feedback enters at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & c_lfsr_taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rbm_hidden_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rbm_hidden_seq_if
// Description : Memory-fetch and result-stream bundle of rbm_hidden_seq.
//               master : the sequencer (drives addresses, h_valid/h_index/
//                        h_data; receives memory words and h_ready)
//               slave  : memories + consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface rbm_hidden_seq_if
  import rbm_hidden_seq_pkg::*;
#(
  parameter int INPUT_BITLENGTH   = 12,
  parameter int SIGMOID_BITLENGTH = 8,
  parameter int IN_DIM            = 784,
  parameter int H_DIM             = 441
) ();
  localparam int c_xaw = addr_width(IN_DIM);
  localparam int c_waw = addr_width(IN_DIM * H_DIM);
  localparam int c_baw = addr_width(H_DIM);

  logic        [c_xaw-1:0]             x_addr;
  logic signed [INPUT_BITLENGTH-1:0]   x_data;
  logic        [c_waw-1:0]             w_addr;
  logic signed [INPUT_BITLENGTH-1:0]   w_data;
  logic        [c_baw-1:0]             b_addr;
  logic signed [INPUT_BITLENGTH-1:0]   b_data;
  logic                                h_valid;
  logic                                h_ready;
  logic        [c_baw-1:0]             h_index;
  logic        [SIGMOID_BITLENGTH-1:0] h_data;

  modport master (
    output x_addr, w_addr, b_addr, h_valid, h_index, h_data,
    input  x_data, w_data, b_data, h_ready
  );

  modport slave (
    input  x_addr, w_addr, b_addr, h_valid, h_index, h_data,
    output x_data, w_data, b_data, h_ready
  );
endinterface
`default_nettype wire

// File: rtl/rbm_hard_sigmoid.sv
`default_nettype none
// ============================================================================
// Module      : rbm_hard_sigmoid
// Description : Combinational hard sigmoid. acc carries 2*FRAC_BITS fraction
//               bits; result is clamp((acc>>>F)/4 + 0.5) reduced to
//               SIGMOID_BITLENGTH bits.
//   acc  in  ACC_W signed accumulator
//   prob out SIGMOID_BITLENGTH unsigned probability
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_hard_sigmoid #(
  parameter int ACC_W             = 35,
  parameter int FRAC_BITS         = 8,
  parameter int SIGMOID_BITLENGTH = 8
) (
  input  logic signed [ACC_W-1:0]             acc,
  output logic        [SIGMOID_BITLENGTH-1:0] prob
);
  localparam logic signed [ACC_W-1:0] c_half = ACC_W'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W-1:0] c_max  = ACC_W'(2 ** FRAC_BITS - 1);

  logic signed [ACC_W-1:0]     w_z;
  logic signed [ACC_W-1:0]     w_p;
  logic        [FRAC_BITS-1:0] w_clamped;

  always_comb begin
    w_z = acc >>> FRAC_BITS;
    w_p = (w_z >>> 2) + c_half;
    if (w_p[ACC_W-1]) begin
      w_clamped = '0;
    end else if (w_p > c_max) begin
      w_clamped = '1;
    end else begin
      w_clamped = w_p[FRAC_BITS-1:0];
    end
    prob = SIGMOID_BITLENGTH'(w_clamped >> (FRAC_BITS - SIGMOID_BITLENGTH));
  end
endmodule
`default_nettype wire

// File: rtl/rbm_hidden_seq.sv
`default_nettype none
// ============================================================================
// Module      : rbm_hidden_seq
// Description : Sequential RBM hidden layer, one MAC, one hidden unit at a
//               time: h_j = hard_sigmoid(b_j + sum_i x_i*w_ij), streamed out
//               as probability or LFSR-driven binary sample.
//   clk, rst            clock / async active-high reset
//   start, sample_mode  begin a pass (IDLE only), output mode captured at start
//   seed_load, seed     LFSR seed (IDLE only)
//   busy, done          pass in progress / one-cycle completion pulse
//   bus (master)        x/w/b memory fetch (1-cycle latency), h_* stream
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_hidden_seq
  import rbm_hidden_seq_pkg::*;
#(
  parameter int INPUT_BITLENGTH   = 12,
  parameter int FRAC_BITS         = 8,
  parameter int SIGMOID_BITLENGTH = 8,
  parameter int IN_DIM            = 784,
  parameter int H_DIM             = 441
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sample_mode,
  input  logic                 seed_load,
  input  logic [15:0]          seed,
  output logic                 busy,
  output logic                 done,
  rbm_hidden_seq_if.master     bus
);
  localparam int c_xaw   = addr_width(IN_DIM);
  localparam int c_waw   = addr_width(IN_DIM * H_DIM);
  localparam int c_baw   = addr_width(H_DIM);
  localparam int c_acc_w = acc_width(INPUT_BITLENGTH, IN_DIM);
  localparam int c_pw    = 2 * INPUT_BITLENGTH;

  state_t                         r_state;
  state_t                         w_state_next;
  logic        [c_xaw-1:0]        r_i;
  logic        [c_waw-1:0]        r_waddr;
  logic        [c_baw-1:0]        r_j;
  logic signed [c_acc_w-1:0]      r_acc;
  logic        [15:0]             r_lfsr;
  logic                           r_mode;
  logic [SIGMOID_BITLENGTH-1:0]   r_h_data;

  logic signed [c_pw-1:0]         w_prod;
  logic signed [c_acc_w-1:0]      w_prod_ext;
  logic signed [c_acc_w-1:0]      w_bias_ext;
  logic [SIGMOID_BITLENGTH-1:0]   w_prob;
  logic [15:0]                    w_lfsr_adv;
  logic                           w_sample;
  logic                           w_last_i;
  logic                           w_last_j;

  assign w_last_i   = (r_i == c_xaw'(IN_DIM - 1));
  assign w_last_j   = (r_j == c_baw'(H_DIM - 1));
  assign w_prod     = bus.x_data * bus.w_data;
  assign w_prod_ext = {{(c_acc_w - c_pw){w_prod[c_pw-1]}}, w_prod};
  assign w_bias_ext = {{(c_acc_w - INPUT_BITLENGTH - FRAC_BITS){bus.b_data[INPUT_BITLENGTH-1]}},
                       bus.b_data, {FRAC_BITS{1'b0}}};

  // The sample is drawn against the LFSR value produced by this unit's step
  assign w_lfsr_adv = lfsr_next(r_lfsr);
  assign w_sample   = (w_lfsr_adv[SIGMOID_BITLENGTH-1:0] < w_prob);

  // Addresses come straight from the counters, so they stay frozen while OUT stalls
  assign bus.x_addr  = r_i;
  assign bus.w_addr  = r_waddr;
  assign bus.b_addr  = r_j;
  assign bus.h_index = r_j;
  assign bus.h_data  = r_h_data;

  rbm_hard_sigmoid #(
    .ACC_W             (c_acc_w),
    .FRAC_BITS         (FRAC_BITS),
    .SIGMOID_BITLENGTH (SIGMOID_BITLENGTH)
  ) u_sigmoid (
    .acc  (r_acc),
    .prob (w_prob)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    bus.h_valid  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_BIAS;
      S_BIAS:  w_state_next = S_MAC;
      S_MAC:   if (w_last_i) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_ACT;
      S_ACT:   w_state_next = S_OUT;
      S_OUT: begin
        bus.h_valid = 1'b1;
        if (bus.h_ready) w_state_next = w_last_j ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i      <= '0;
      r_waddr  <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_lfsr   <= c_seed_zero_sub;
      r_mode   <= 1'b0;
      r_h_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Seed first so a same-cycle start runs with the new seed
          if (seed_load) r_lfsr <= (seed == 16'h0000) ? c_seed_zero_sub : seed;
          if (start) begin
            r_mode  <= sample_mode;
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
          end
        end
        S_MAC: begin
          r_i     <= w_last_i ? '0 : r_i + 1'b1;
          // Runs on into the next unit's base j*IN_DIM without a multiplier
          r_waddr <= r_waddr + 1'b1;
          // First MAC cycle sees the bias fetched in BIAS; later ones the previous product
          r_acc   <= (r_i == '0) ? w_bias_ext : r_acc + w_prod_ext;
        end
        S_DRAIN: r_acc <= r_acc + w_prod_ext;
        S_ACT: begin
          r_lfsr   <= w_lfsr_adv;
          r_h_data <= r_mode ? SIGMOID_BITLENGTH'(w_sample) : w_prob;
        end
        S_OUT: if (bus.h_ready) r_j <= w_last_j ? '0 : r_j + 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rbm_hidden_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbm_hidden_seq
// Description : Self-checking bench for rbm_hidden_seq (IN_DIM=4, H_DIM=3)
//               with 1-cycle memory models and a behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbm_hidden_seq;
  localparam int IB = 12, FB = 8, SB = 8, ND = 4, HD = 3;
  localparam int UNIT = ND + 4;

  logic        clk = 1'b0;
  logic        rst, start, sample_mode, seed_load;
  logic [15:0] seed;
  logic        busy, done;

  rbm_hidden_seq_if #(.INPUT_BITLENGTH(IB), .SIGMOID_BITLENGTH(SB),
                      .IN_DIM(ND), .H_DIM(HD)) bus ();

  rbm_hidden_seq #(.INPUT_BITLENGTH(IB), .FRAC_BITS(FB), .SIGMOID_BITLENGTH(SB),
                   .IN_DIM(ND), .H_DIM(HD)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_mode(sample_mode),
    .seed_load(seed_load), .seed(seed), .busy(busy), .done(done), .bus(bus));

  always #5 clk = ~clk;

  logic signed [IB-1:0] xmem [ND];
  logic signed [IB-1:0] wmem [ND*HD];
  logic signed [IB-1:0] bmem [HD];

  always @(posedge clk) begin
    bus.x_data <= xmem[bus.x_addr];
    bus.w_data <= (int'(bus.w_addr) < ND*HD) ? wmem[bus.w_addr] : '0;
    bus.b_data <= (int'(bus.b_addr) < HD) ? bmem[bus.b_addr] : '0;
  end

  int          n_checks = 0, n_errors = 0;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Fixed-point: bias scaled by 2^FB to align with x*w products (2*FB fraction bits)
  function automatic int ref_prob(input int j);
    longint acc, z, p;
    acc = longint'(bmem[j]) * (longint'(1) << FB);
    for (int i = 0; i < ND; i++) acc += longint'(xmem[i]) * longint'(wmem[j*ND + i]);
    z = acc >>> FB;
    p = (z >>> 2) + (longint'(1) << (FB - 1));
    if (p < 0) p = 0;
    if (p > (longint'(1) << FB) - 1) p = (longint'(1) << FB) - 1;
    return int'(p >> (FB - SB));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < ND; i++)    xmem[i] = IB'($urandom);
    for (int i = 0; i < ND*HD; i++) wmem[i] = IB'($urandom);
    for (int i = 0; i < HD; i++)    bmem[i] = IB'($urandom);
  endtask

  // One full pass; st_unit/st_len hold h_ready low on one unit, poke pulses
  // start+seed_load while busy at that cycle number (0 = never).
  task automatic run_pass(input bit mode, input bit ld, input logic [15:0] sd,
                          input int st_unit, input int st_len, input int poke);
    int          exp_d [HD];
    int          cyc, hs, done_cyc, stall_left, p, exp_cyc;
    logic [31:0] hold;
    if (ld) m_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int j = 0; j < HD; j++) begin
      p = ref_prob(j);
      m_lfsr = ref_lfsr_step(m_lfsr);
      exp_d[j] = mode ? ((int'(m_lfsr[SB-1:0]) < p) ? 1 : 0) : p;
    end
    @(negedge clk);
    start = 1'b1; sample_mode = mode; seed_load = ld; seed = sd; bus.h_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; sample_mode = 1'($urandom);
    cyc = 1; hs = 0; done_cyc = 0; stall_left = st_len; hold = '0;
    while (done_cyc == 0 && cyc < 200) begin
      if (cyc == poke) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'($urandom);
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        check("done_valid_excl", 32'(bus.h_valid), 32'd0);
      end else if (bus.h_valid) begin
        if (hs == st_unit && stall_left > 0) begin
          if (stall_left == st_len)
            hold = 32'({bus.h_index, bus.h_data, bus.x_addr, bus.w_addr, bus.b_addr});
          else
            check("stall_stable", 32'({bus.h_index, bus.h_data, bus.x_addr, bus.w_addr, bus.b_addr}), hold);
          bus.h_ready = 1'b0;
          stall_left--;
        end else begin
          bus.h_ready = 1'b1;
          exp_cyc = UNIT * (hs + 1) + ((st_len > 0 && hs >= st_unit) ? st_len : 0);
          check("h_index", 32'(bus.h_index), 32'(hs));
          check("h_data", 32'(bus.h_data), 32'(exp_d[hs]));
          check("h_cycle", 32'(cyc), 32'(exp_cyc));
          hs++;
        end
      end else begin
        bus.h_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; seed_load = 1'b0; bus.h_ready = 1'b1;
    check("done_cycle", 32'(done_cyc), 32'(HD * UNIT + 1 + st_len));
    check("units_out", 32'(hs), 32'(HD));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_mode = 1'b0; seed_load = 1'b0; seed = '0;
    bus.h_ready = 1'b1;
    m_lfsr = 16'h0001;
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_h_valid", 32'(bus.h_valid), 32'd0);
    check("rst_h_index", 32'(bus.h_index), 32'd0);
    check("rst_h_data", 32'(bus.h_data), 32'd0);
    check("rst_addrs", 32'({bus.x_addr, bus.w_addr, bus.b_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero weights, biases 0 / +4.0 / -4.0
    for (int i = 0; i < ND*HD; i++) wmem[i] = '0;
    bmem[0] = 12'h000; bmem[1] = 12'h400; bmem[2] = 12'hC00;
    run_pass(1'b0, 1'b0, 16'h0, -1, 0, 0);

    // x = 1.0, w = 0.25, no bias; then the same with a 5-cycle stall on unit 1
    for (int i = 0; i < ND; i++)    xmem[i] = 12'h100;
    for (int i = 0; i < ND*HD; i++) wmem[i] = 12'h040;
    for (int i = 0; i < HD; i++)    bmem[i] = 12'h000;
    run_pass(1'b0, 1'b0, 16'h0, -1, 0, 0);
    run_pass(1'b0, 1'b0, 16'h0, 1, 5, 0);

    // Sample mode: seed 0 must behave as seed 1, and repeat identically
    for (int i = 0; i < ND*HD; i++) wmem[i] = '0;
    bmem[0] = 12'h400; bmem[1] = 12'hC00; bmem[2] = 12'h400;
    run_pass(1'b1, 1'b1, 16'h0000, -1, 0, 0);
    run_pass(1'b1, 1'b1, 16'h0001, -1, 0, 0);

    // start/seed_load pulsed while busy must be ignored
    fill_random();
    run_pass(1'b1, 1'b0, 16'h0, -1, 0, 12);
    run_pass(1'b0, 1'b0, 16'h0, -1, 0, 3);

    // Reset during MAC of unit 1 (cycle 11), then a clean pass
    @(negedge clk);
    start = 1'b1; sample_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_in_unit1", 32'({busy, bus.h_index}), 32'({1'b1, 2'd1}));
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", 32'({busy, bus.h_valid, done}), 32'd0);
    rst = 1'b0;
    m_lfsr = 16'h0001;
    run_pass(1'b0, 1'b0, 16'h0, -1, 0, 0);

    // Randomized passes
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_pass(1'($urandom), 1'($urandom), 16'($urandom),
               int'($urandom_range(0, HD-1)), int'($urandom_range(0, 6)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
